// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, timing defaults and command bytes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        ERROR     = 3'd6
    } ps2_state_e;

    // 50 MHz defaults: 120 us inhibit, 15 ms start window, 2 ms packet window
    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_PACKET_TIMEOUT = 100000;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Bits after the start bit, LSB first: data, odd parity, stop
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command-byte handshake between a requester and the PS/2 transmitter
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer for PS/2 CLK/DAT with CLK falling-edge pulse
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Idle bus level is high, so resetting to 1 avoids a false edge after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_raw};
            dat_ff   <= {dat_ff[0], dat_raw};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync = clk_ff[1];
    assign dat_sync = dat_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with inhibit, ACK check and timeouts
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);

    localparam int TMAX = max3(INHIBIT_CYCLES, START_TIMEOUT, PACKET_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] INH_END    = TW'(INHIBIT_CYCLES);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] PKT_LAST   = TW'(PACKET_TIMEOUT - 1);

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk      (CLOCK_50),
        .reset    (reset),
        .clk_raw  (ps2_clk_in),
        .dat_raw  (ps2_dat_in),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_fall (clk_fall)
    );

    ps2_state_e    state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [9:0]    shreg, shreg_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          accept;

    // Ready is held off during the done pulse so the next accept lands a cycle later
    assign tx.tx_ready = (state == IDLE) && !done_q;
    assign tx.tx_busy  = (state != IDLE);
    assign tx.tx_done  = done_q;
    assign tx.tx_error = (state == ERROR);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign accept      = tx.tx_valid && tx.tx_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (accept) begin
                    shreg_d   = ps2_frame(tx.tx_data);
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_oe_d = 1'b1;
                timer_d  = timer + TW'(1);
                if (timer == INH_LAST) begin
                    dat_oe_d = 1'b1;
                end
                if (timer == INH_END) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    timer_d  = '0;
                    state_d  = REQUEST;
                end
            end

            REQUEST: begin
                timer_d = timer + TW'(1);
                // Expiry is tested first so a coincident edge cannot rescue a late device
                if (timer == START_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_fall) begin
                    dat_oe_d  = ~shreg[0];
                    shreg_d   = {1'b0, shreg[9:1]};
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = DATA;
                end
            end

            DATA: begin
                timer_d = timer + TW'(1);
                if (timer == PKT_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_fall) begin
                    dat_oe_d  = ~shreg[0];
                    shreg_d   = {1'b0, shreg[9:1]};
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end

            ACK: begin
                timer_d = timer + TW'(1);
                if (timer == PKT_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = dat_sync ? ERROR : WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                timer_d = timer + TW'(1);
                if (timer == PKT_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
                end else if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            ERROR: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte from the FPGA to a PS/2 keyboard or mouse, for example 0xED (set LEDs) or 0xFF (reset). It is the send-direction counterpart of the existing PS/2 receive path. It sits beside `PS2_Comm` under `top` and shares the open-drain `PS2_CLK`/`PS2_DAT` lines with it. The block implements the inhibit, request-to-send, data-frame and acknowledge sequence, with timeouts.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 6000: clock-low hold time before request-to-send (120 µs at 50 MHz).
- `START_TIMEOUT`, default 750000: maximum wait from clock release to the first device falling edge (15 ms).
- `PACKET_TIMEOUT`, default 100000: maximum time from the first falling edge to ACK plus idle (2 ms).

Ports:
- `CLOCK_50`  in  1  system clock. One clock domain; synchronous, active-high reset.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  command byte, sampled only on accept.
- `tx_valid`  in  1  send request.
- `tx_ready`  out  1  high only in IDLE; accept occurs when `tx_valid & tx_ready`.
- `tx_busy`  out  1  high whenever state is not IDLE. The receiver ignores frames while this is high.
- `tx_done`  out  1  one-cycle pulse on successful ACK.
- `tx_error`  out  1  one-cycle pulse on timeout or missing ACK.
- `ps2_clk_in`  in  1  raw PS2_CLK pin value (asynchronous).
- `ps2_dat_in`  in  1  raw PS2_DAT pin value (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive PS2_CLK low; 0 = release. Top level does `PS2_CLK = oe ? 0 : z`.
- `ps2_dat_oe`  out  1  1 = drive PS2_DAT low; 0 = release.

## Operation
- Input conditioning: both pins pass through a 2-FF synchronizer. A falling-edge pulse `clk_fall` is generated from the synchronized clock.
- Reset values:
  - state = IDLE, `tx_ready` = 1.
  - `tx_busy`, `tx_done`, `tx_error`, `ps2_clk_oe`, `ps2_dat_oe` all 0.
  - All counters 0.
- IDLE: on accept, latch `shreg = {1'b1 (stop), ~^tx_data (odd parity), tx_data}`. Clear the timer and go to INHIBIT.
- INHIBIT: `clk_oe` = 1, timer counts up.
  - At timer = INHIBIT_CYCLES−1, set `dat_oe` = 1 (start bit).
  - At timer = INHIBIT_CYCLES, go to REQUEST, clear the timer, set `clk_oe` = 0.
- REQUEST: `dat_oe` = 1, clock released.
  - On `clk_fall`, drive bit 0 (`dat_oe = ~shreg[0]`), shift, set `bit_cnt` = 1, clear the timer, go to DATA.
  - If timer reaches START_TIMEOUT, go to ERROR.
- DATA: on each `clk_fall`, drive the next LSB-first bit (`dat_oe = ~bit`).
  - `bit_cnt` 1..8 carry data bit 1..7 then parity; the 10th falling edge releases DAT (stop bit = 1).
  - After the stop bit is driven, go to ACK.
- ACK: wait for the next `clk_fall`.
  - Synchronized DAT = 0 → go to WAIT_IDLE.
  - Synchronized DAT = 1 → go to ERROR.
- WAIT_IDLE: when synced CLK and DAT are both 1, pulse `tx_done` and go to IDLE.
- PACKET_TIMEOUT runs from entering DATA through WAIT_IDLE. On expiry, go to ERROR.
- ERROR: `clk_oe` = `dat_oe` = 0, pulse `tx_error` for one cycle, go to IDLE.
- Boundary cases:
  - `tx_valid` outside IDLE is ignored, not queued.
  - `tx_data` changes after accept have no effect.
  - Reset mid-frame releases both lines on the next edge and returns to IDLE with no done/error pulse.
  - A `clk_fall` in the same cycle as timeout expiry: timeout wins.

## Timing
- Accept to `clk_oe` = 1: 1 cycle.
- `clk_oe` is asserted for exactly INHIBIT_CYCLES+1 cycles.
- `dat_oe` rises 1 cycle before `clk_oe` falls.
- Bit update latency: `dat_oe` changes 3 cycles after the raw pin falling edge (2 sync + 1 register).
- `tx_done` is asserted 3 cycles after both raw lines are high.
- `tx_ready` rises the cycle after a `tx_done` or `tx_error` pulse. Back-to-back sends are allowed from then on.

## Structure
- Shared package `ps2_pkg`:
  - State encoding (IDLE, INHIBIT, REQUEST, DATA, ACK, WAIT_IDLE, ERROR).
  - Default timing constants.
  - Common command byte constants: `CMD_SET_LEDS` = 0xED, `CMD_RESET` = 0xFF, `ACK_BYTE` = 0xFA.
- Sub-module `ps2_line_sync`: 2-FF synchronizer plus falling-edge detector for CLK and DAT. Reusable by the receiver.
- Single FSM with:
  - a timer wide enough for START_TIMEOUT (20 bits at default)
  - 4-bit `bit_cnt`
  - 10-bit shift register

## Test plan
The bench uses INHIBIT_CYCLES = 20, START_TIMEOUT = 400, PACKET_TIMEOUT = 2000, and a device model clocking at a 40-cycle period.
- Send 0xED, device ACKs → CLK held low exactly 21 cycles. Device samples start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. `tx_done` pulses once; `tx_error` stays 0.
- Send 0x01 → device samples data 1,0,0,0,0,0,0,0, parity 0. `tx_done` pulses.
- Device never clocks after release → `tx_error` pulses 400 cycles after the clock is released. Both `oe` outputs are 0, and `tx_ready` = 1 on the next cycle.
- Device leaves DAT high at the 11th falling edge → `tx_error` pulses with no `tx_done`.
- Reset asserted after the 4th falling edge → both `oe` outputs are 0 and `tx_ready` = 1 one cycle later, with no done/error pulse.
- `tx_valid` held high with 0x55 then 0xAA during a transfer → 0x55 is sent alone. 0xAA is accepted only after `tx_done`; its frame carries parity 1.
